// File: rtl/hx711_reader.sv
// HX711 load-cell ADC reader: waits for DOUT ready, shifts 24 bits, sends gain-select pulses.
// Handles power-down and data-ready timeout. Define HX711_AVG_EN to average 2^AVG_LOG2 results per output.
module hx711_reader #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int SCK_FREQ_HZ = 50_000,
    parameter int OUT_W       = 32,
    parameter int TIMEOUT_CYC = 10_000_000
`ifdef HX711_AVG_EN
    ,
    parameter int AVG_LOG2    = 2
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hx_dt,
    output logic             hx_sck,
    input  logic             enable,
    input  logic [1:0]       gain_sel,
    input  logic             pd_req,
    output logic [OUT_W-1:0] sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun,
    output logic             timeout,
    output logic             busy
);
    localparam int HALF = CLK_FREQ_HZ / (2 * SCK_FREQ_HZ);
    localparam int PH_W = $clog2(HALF);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_DRDY, S_SHIFT, S_EXTRA, S_DONE, S_PD} state_t;

    state_t            state_q, state_d;
    logic              dt_meta_q, dt_sync_q;
    logic              sck_q, sck_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [4:0]        pulse_q, pulse_d, pulse_nxt, total;
    logic [23:0]       shift_q, shift_d;
    logic [1:0]        gain_q, gain_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              timeout_q, timeout_d;
    logic              frame_done;
    logic [OUT_W-1:0]  data_q, data_d, new_data;
    logic              valid_q, valid_d, overrun_q, overrun_d, new_sample;

    // 24 data pulses plus 1/2/3 gain-select pulses for latched gain 00/01/10.
    assign total     = 5'd25 + {3'b000, gain_q};
    assign pulse_nxt = pulse_q + 5'd1;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d    = state_q;
        sck_d      = sck_q;
        ph_d       = ph_q;
        pulse_d    = pulse_q;
        shift_d    = shift_q;
        gain_d     = gain_q;
        to_d       = '0;
        timeout_d  = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                sck_d = 1'b0;
                if (pd_req) begin
                    state_d = S_PD;
                    sck_d   = 1'b1;
                end else if (enable) begin
                    state_d = S_WAIT_DRDY;
                end
            end
            S_WAIT_DRDY: begin
                sck_d = 1'b0;
                if (pd_req) begin
                    state_d = S_PD;
                    sck_d   = 1'b1;
                end else if (!enable) begin
                    state_d = S_IDLE;
                end else if (!dt_sync_q) begin
                    state_d = S_SHIFT;
                    sck_d   = 1'b1;
                    ph_d    = '0;
                    pulse_d = '0;
                    gain_d  = (gain_sel == 2'b11) ? 2'b00 : gain_sel;
                end else if (to_q == TO_LAST) begin
                    timeout_d = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_SHIFT, S_EXTRA: begin
                ph_d = ph_q + 1'b1;
                if (ph_q == PH_LAST) begin
                    ph_d = '0;
                    if (sck_q) begin
                        // Last clk of the high phase: DOUT has settled after the rising edge.
                        sck_d = 1'b0;
                        if (state_q == S_SHIFT) shift_d = {shift_q[22:0], dt_sync_q};
                    end else begin
                        pulse_d = pulse_nxt;
                        if (pulse_nxt == total) begin
                            state_d = S_DONE;
                        end else begin
                            sck_d   = 1'b1;
                            state_d = (pulse_nxt < 5'd24) ? S_SHIFT : S_EXTRA;
                        end
                    end
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                if (pd_req) begin
                    state_d = S_PD;
                    sck_d   = 1'b1;
                end else begin
                    state_d = enable ? S_WAIT_DRDY : S_IDLE;
                end
            end
            S_PD: begin
                sck_d = 1'b1;
                if (!pd_req) begin
                    // The device wakes up at channel A / gain 128.
                    sck_d   = 1'b0;
                    state_d = S_WAIT_DRDY;
                    gain_d  = 2'b00;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef HX711_AVG_EN
    localparam int ACC_W = OUT_W + AVG_LOG2;

    logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
    logic [AVG_LOG2:0] cnt_q, cnt_d;
    logic              acc_clr;

    always_comb begin
        acc_sum    = acc_q + ACC_W'($signed(shift_q));
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        new_sample = 1'b0;
        new_data   = OUT_W'($signed(acc_sum) >>> AVG_LOG2);
        acc_clr    = !enable || (state_d == S_PD && state_q != S_PD) || (gain_d != gain_q);
        if (acc_clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (frame_done) begin
            if (int'(cnt_q) == (1 << AVG_LOG2) - 1) begin
                new_sample = 1'b1;
                acc_d      = '0;
                cnt_d      = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        new_sample = frame_done;
        new_data   = OUT_W'($signed(shift_q));
    end
`endif

    // A fresh result in the same cycle as an accept keeps valid high without overrun.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q && !sample_ready;
        overrun_d = 1'b0;
        if (new_sample) begin
            data_d    = new_data;
            valid_d   = 1'b1;
            overrun_d = valid_q && !sample_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            dt_meta_q <= 1'b1;
            dt_sync_q <= 1'b1;
            state_q   <= S_IDLE;
            sck_q     <= 1'b0;
            ph_q      <= '0;
            pulse_q   <= '0;
            shift_q   <= '0;
            gain_q    <= 2'b00;
            to_q      <= '0;
            timeout_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            dt_meta_q <= hx_dt;
            dt_sync_q <= dt_meta_q;
            state_q   <= state_d;
            sck_q     <= sck_d;
            ph_q      <= ph_d;
            pulse_q   <= pulse_d;
            shift_q   <= shift_d;
            gain_q    <= gain_d;
            to_q      <= to_d;
            timeout_q <= timeout_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign hx_sck       = sck_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign timeout      = timeout_q;
    assign busy         = (state_q == S_SHIFT) || (state_q == S_EXTRA);

endmodule

// File: tb/tb_hx711_reader.sv
// Self-checking bench for hx711_reader: behavioural HX711 device model, directed vector
// table, randomized frames against an arithmetic reference, plus handshake/PD/timeout/reset sequences.
module tb_hx711_reader;
    localparam int CLK_HZ = 2_000_000;
    localparam int SCK_HZ = 250_000;
    localparam int OUT_W  = 32;
    localparam int TO_CYC = 1000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             hx_dt = 1'b1;
    logic             enable = 1'b0;
    logic             pd_req = 1'b0;
    logic             sample_ready = 1'b0;
    logic [1:0]       gain_sel = 2'b00;
    logic             hx_sck, sample_valid, overrun, timeout, busy;
    logic [OUT_W-1:0] sample_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hx711_reader #(
        .CLK_FREQ_HZ(CLK_HZ),
        .SCK_FREQ_HZ(SCK_HZ),
        .OUT_W      (OUT_W),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hx_dt       (hx_dt),
        .hx_sck      (hx_sck),
        .enable      (enable),
        .gain_sel    (gain_sel),
        .pd_req      (pd_req),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun     (overrun),
        .timeout     (timeout),
        .busy        (busy)
    );

    // HX711 model: DOUT low means ready; each SCK rising edge shifts out the next bit MSB first.
    logic [23:0] dev_word = '0;
    int          dev_edge = 0;
    bit          dev_active = 1'b0;
    int          sck_edges = 0;

    always @(posedge hx_sck) begin
        sck_edges++;
        if (dev_active) begin
            dev_edge++;
            #1;
            if (dev_edge <= 24) hx_dt = dev_word[24 - dev_edge];
            else begin
                hx_dt      = 1'b1;
                dev_active = 1'b0;
            end
        end
    end

    int cyc = 0, ov_cnt = 0, to_cnt = 0;
    int to_cyc_q[$];
    bit valid_watch = 1'b0, valid_dropped = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (overrun) ov_cnt++;
        if (timeout) begin
            to_cnt++;
            to_cyc_q.push_back(cyc);
        end
        if (valid_watch && !sample_valid) valid_dropped = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int ref_pulses(input logic [1:0] g);
        return (g == 2'd1) ? 26 : (g == 2'd2) ? 27 : 25;
    endfunction

    function automatic logic [OUT_W-1:0] ref_data(input logic [23:0] w);
        longint v;
        v = longint'(w);
        if (v >= 8388608) v = v - 16777216;
        return OUT_W'(v);
    endfunction

    task automatic dev_start(input logic [23:0] w);
        sck_edges  = 0;
        dev_word   = w;
        dev_edge   = 0;
        dev_active = 1'b1;
        hx_dt      = 1'b0;
    endtask

    task automatic run_frame(input logic [23:0] w, input logic [1:0] g, output int pulses);
        int n;
        gain_sel = g;
        dev_start(w);
        n = 0;
        while (!busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("frame_start", busy, 1);
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("frame_end", busy, 0);
        pulses = sck_edges;
        @(negedge clk);
    endtask

    task automatic accept(input string name);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        check({name, "_valid_clr"}, sample_valid, 0);
    endtask

    typedef struct {
        logic [23:0] word;
        logic [1:0]  gain;
        int          pulses;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int          p, n, d;
        logic [23:0] w;
        logic [1:0]  g;
        logic [23:0] avg_in[4];

        vecs[0] = '{24'h123456, 2'd0, 25, 32'h00123456};
        vecs[1] = '{24'hFFFFFE, 2'd1, 26, 32'hFFFFFFFE};
        vecs[2] = '{24'hFFFFFE, 2'd2, 27, 32'hFFFFFFFE};
        vecs[3] = '{24'h800000, 2'd3, 25, 32'hFF800000};
        vecs[4] = '{24'h7FFFFF, 2'd0, 25, 32'h007FFFFF};
        avg_in  = '{24'd4, 24'd8, 24'hFFFFFC, 24'd0};

        rst_n  = 1'b0;
        enable = 1'b1;
        hx_dt  = 1'b1;
        tick(3);
        check("rst_sck", hx_sck, 0);
        check("rst_data", sample_data, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(20);
        check("idle_sck_edges", sck_edges, 0);
        check("idle_sck", hx_sck, 0);
        check("idle_busy", busy, 0);

`ifdef HX711_AVG_EN
        for (int i = 0; i < 4; i++) begin
            run_frame(avg_in[i], 2'd0, p);
            if (i < 3) check($sformatf("avg%0d_no_valid", i), sample_valid, 0);
        end
        check("avg_valid", sample_valid, 1);
        check("avg_data", sample_data, 32'd2);
        accept("avg");
`else
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].word, vecs[i].gain, p);
            check($sformatf("vec%0d_pulses", i), p, vecs[i].pulses);
            check($sformatf("vec%0d_data", i), sample_data, vecs[i].data);
            check($sformatf("vec%0d_valid", i), sample_valid, 1);
            if (i == 0) begin
                tick(5);
                check("vec0_valid_hold", sample_valid, 1);
            end
            accept($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            w = 24'($urandom);
            g = 2'($urandom_range(0, 3));
            run_frame(w, g, p);
            check($sformatf("rnd%0d_pulses", i), p, ref_pulses(g));
            check($sformatf("rnd%0d_data", i), sample_data, ref_data(w));
            check($sformatf("rnd%0d_valid", i), sample_valid, 1);
            tick($urandom_range(0, 3));
            accept($sformatf("rnd%0d", i));
        end

        // Two results with no accept in between: second overwrites, one overrun pulse.
        ov_cnt = 0;
        run_frame(24'h000111, 2'd0, p);
        valid_watch = 1'b1;
        run_frame(24'hABCDEF, 2'd0, p);
        tick(2);
        check("ovr_count", ov_cnt, 1);
        check("ovr_data", sample_data, ref_data(24'hABCDEF));
        check("ovr_valid_held", valid_dropped, 0);
        valid_watch = 1'b0;
        accept("ovr");

        // Power-down requested mid-frame: frame completes, then SCK held high.
        gain_sel = 2'd0;
        dev_start(24'h00ABCD);
        n = 0;
        while (sck_edges < 10 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("pd_midframe_busy", busy, 1);
        pd_req = 1'b1;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("pd_frame_end", busy, 0);
        check("pd_frame_pulses", sck_edges, 25);
        tick(2);
        check("pd_data", sample_data, ref_data(24'h00ABCD));
        check("pd_sck_high", hx_sck, 1);
        tick(30);
        check("pd_sck_hold", hx_sck, 1);
        check("pd_busy", busy, 0);
        accept("pd");
        pd_req = 1'b0;
        tick(2);
        check("pd_exit_sck", hx_sck, 0);
        run_frame(24'h654321, 2'd0, p);
        check("post_pd_pulses", p, 25);
        check("post_pd_data", sample_data, ref_data(24'h654321));
        accept("post_pd");
`endif

        // DOUT never goes low: timeout pulses every TO_CYC cycles, no SCK activity.
        enable = 1'b0;
        tick(3);
        to_cnt = 0;
        to_cyc_q.delete();
        sck_edges = 0;
        d = cyc;
        enable = 1'b1;
        tick(2100);
        check("to_count", to_cnt, 2);
        if (to_cyc_q.size() >= 2) begin
            check("to_first_window", (to_cyc_q[0] - d >= 999) && (to_cyc_q[0] - d <= 1003), 1);
            check("to_gap", to_cyc_q[1] - to_cyc_q[0], TO_CYC);
        end
        check("to_no_sck", sck_edges, 0);
        check("to_busy", busy, 0);

`ifndef HX711_AVG_EN
        // Asynchronous reset during SCK high drops SCK at once and discards the frame.
        dev_start(24'h0F0F0F);
        n = 0;
        while (!(sck_edges >= 5 && hx_sck) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("arst_pre_sck", hx_sck, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sck", hx_sck, 0);
        check("arst_busy", busy, 0);
        dev_active = 1'b0;
        hx_dt      = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);
        check("arst_valid", sample_valid, 0);
        run_frame(24'h800001, 2'd2, p);
        check("arst_recover_pulses", p, 27);
        check("arst_recover_data", sample_data, ref_data(24'h800001));
        accept("arst_recover");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
